axi_irctx_control: RTL
======================

# axi_irctx_control

AXI4-lite controlled transmit front end for the IR/UART link: the processor programs the baud divisor and pushes bytes through a memory-mapped data register, and the block buffers them in a 4-entry FIFO and delivers them to the UART transmitter over an 8-bit AXI4-stream master. It pairs with the receive-side control block and drives the same `mod_m` divisor convention into the transmitter's baud generator.

## Interface
- `C_ADDR_WIDTH`, 32, AXI4-lite address width
- `C_DATA_WIDTH`, 32, AXI4-lite data width (only 32 supported)
- `aclk` in 1: single clock for all logic
- `aresetn` in 1: asynchronous, active-low reset
- `s_axi_aw*`, `s_axi_w*`, `s_axi_b*`, `s_axi_ar*`, `s_axi_r*`: standard AXI4-lite slave port, widths from the parameters; `bresp` and `rresp` are always `2'b00`
- `m_axis_tdata` out 8: byte at the FIFO head
- `m_axis_tvalid` out 1: FIFO not empty
- `m_axis_tready` in 1: transmitter accepts the byte
- `mod_m` out 16: baud divisor, equal to CTRL[15:0]

## Operation
- Register map, decoded on address bits [3:0]:
  - 0x00 CTRL: [15:0] baud (R/W, byte strobes 0 and 1 honoured); [16] full (R); [17] empty (R); [20:18] level 0..4 (R); [21] overflow (R, W1C); other bits read 0.
  - 0x04 TXDR: a write with `wstrb[0]`=1 pushes `wdata[7:0]`; reads return 0.
  - 0x08, 0x0C: reserved; read 0; writes ignored but still acknowledged.
- Write FSM:
  - WRIDLE (`awready`=1) goes to WRDATA on `awvalid`; the address is latched on the aw handshake.
  - WRDATA (`wready`=1) goes to WRRESP on `wvalid`; the register update happens on this w handshake.
  - WRRESP (`bvalid`=1) returns to WRIDLE on `bready`.
- Read FSM:
  - RDIDLE (`arready`=1) goes to RDDATA on `arvalid`; `rdata` is registered on the ar handshake.
  - RDDATA (`rvalid`=1) returns to RDIDLE on `rready`.
- FIFO: 4 x 8-bit storage with 2-bit read and write pointers and a 3-bit count.
  - Push: a TXDR write with count < 4.
  - Pop: `m_axis_tvalid` && `m_axis_tready`.
  - Pointers wrap modulo 4.
- Full push: a TXDR write while count == 4 drops the byte and sets overflow. This holds even if a pop occurs in the same cycle, because full is sampled before the update.
- Simultaneous push (count < 4) and pop: count is unchanged and both pointers advance.
- Overflow is sticky. It is cleared by a CTRL write with `wdata[21]`=1 and `wstrb[2]`=1. If a drop and a clear happen in the same cycle, the set wins.
- A baud write does not disturb the FIFO or the stream.
- AXIS rules: `m_axis_tdata` is held stable while `tvalid` is high and `tready` is low. `tvalid` never drops without a handshake, except on reset.

## Timing
- Reset (async assert, sync-released by the system) gives:
  - both FSMs idle: `awready`=1, `arready`=1, `wready`=`bvalid`=`rvalid`=0
  - `rdata`=0, `mod_m`=0
  - FIFO empty: `m_axis_tvalid`=0, `m_axis_tdata`=0; count 0, overflow 0
- Reset mid-transfer aborts the AXI transaction and discards FIFO contents.
- Write latency: with aw handshake at edge N and w handshake at edge N+1, the pushed byte drives `m_axis_tvalid`=1 from edge N+1, and `bvalid` is asserted at edge N+1.
- Read latency: `rvalid` is asserted one cycle after the ar handshake. Status reflects the register state at the ar handshake edge.
- Stream throughput: one byte per cycle while the FIFO is non-empty and `tready`=1.
- A pushed byte into an empty FIFO is presented the cycle after the push. The data path has no combinational path from AXI-lite inputs to AXIS outputs.

## Test plan
- Reset, then read 0x00: expect `rdata`=0x00020000 (empty=1, level 0, baud 0) and `mod_m`=0.
- Write 0x00 = 0x0000_01B2 with `wstrb`=0xF: expect `mod_m`=0x01B2, and a read of 0x00 returns 0x000201B2.
- With `tready`=0, write TXDR with 0xA1, 0xB2, 0xC3, 0xD4:
  - after the writes: level 4, full=1, `tdata`=0xA1 held stable
  - a fifth write of 0xE5 leaves level 4 and sets bit 21
  - raising `tready` for 4 cycles emits A1, B2, C3, D4 in order, then `tvalid`=0
- At level 2 with `tready`=1, issue a TXDR write in the same cycle as a pop: level stays 2 and the byte order is preserved across pointer wrap.
- Write 0x00 with bit 21=1 and `wstrb`=0x4: overflow reads 0 and baud is unchanged.
- Assert `aresetn`=0 mid-stream at level 3 with `bvalid` pending: all outputs return to reset values immediately, and the next read of 0x00 returns 0x00020000.

Source files
------------

// File: rtl/axi_irctx_control.sv
// AXI4-lite controlled IR/UART transmit front end: baud divisor register,
// 4-entry byte FIFO fed through a data register, drained over 8-bit AXI4-stream.
module axi_irctx_control #(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // AXI4-lite write address
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    // AXI4-lite write data
    input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    // AXI4-lite write response
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    // AXI4-lite read address
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    // AXI4-lite read data
    output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    // AXI4-stream master to the transmitter
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    // Baud divisor
    output logic [15:0]                 mod_m
);

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned DEC_W   = 4;
    localparam logic [DEC_W-1:0] A_CTRL = 4'h0;
    localparam logic [DEC_W-1:0] A_TXDR = 4'h4;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_t;
    typedef enum logic [0:0] {RDIDLE, RDDATA} rstate_t;

    wstate_t                r_wstate;
    rstate_t                r_rstate;
    logic [DEC_W-1:0]       r_awaddr;
    logic [C_DATA_WIDTH-1:0] r_rdata;
    logic [15:0]            r_baud;
    logic                   r_ovf;
    logic [7:0]             r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_wr_hs;
    logic                   w_wr_ctrl;
    logic                   w_wr_txdr;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_ovf_clr;
    logic [31:0]            w_ctrl_rd;
    logic                   w_unused;

    // Write-side decode; full/empty come from the count before this cycle's update
    assign w_wr_hs   = (r_wstate == WRDATA) && s_axi_wvalid;
    assign w_wr_ctrl = w_wr_hs && (r_awaddr == A_CTRL);
    assign w_wr_txdr = w_wr_hs && (r_awaddr == A_TXDR) && s_axi_wstrb[0];
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = w_wr_txdr && !w_full;
    assign w_drop    = w_wr_txdr && w_full;
    assign w_pop     = !w_empty && m_axis_tready;
    assign w_ovf_clr = w_wr_ctrl && s_axi_wstrb[2] && s_axi_wdata[21];
    assign w_ctrl_rd = {10'd0, r_ovf, r_count, w_empty, w_full, r_baud};

    // Address and data bits outside the decoded register fields
    assign w_unused = &{1'b0, s_axi_awaddr[C_ADDR_WIDTH-1:DEC_W], s_axi_araddr[C_ADDR_WIDTH-1:DEC_W],
                        s_axi_wdata[C_DATA_WIDTH-1:22], s_axi_wdata[20:16], s_axi_wstrb[C_DATA_WIDTH/8-1:3]};

    // Outputs derived only from registered state
    assign s_axi_awready = (r_wstate == WRIDLE);
    assign s_axi_wready  = (r_wstate == WRDATA);
    assign s_axi_bvalid  = (r_wstate == WRRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = (r_rstate == RDIDLE);
    assign s_axi_rvalid  = (r_rstate == RDDATA);
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = r_rdata;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = r_mem[r_rptr];
    assign mod_m         = r_baud;

    // Write channel FSM with address latch
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate <= WRIDLE;
            r_awaddr <= '0;
        end else begin
            case (r_wstate)
                WRIDLE: if (s_axi_awvalid) begin
                    r_awaddr <= s_axi_awaddr[DEC_W-1:0];
                    r_wstate <= WRDATA;
                end
                WRDATA: if (s_axi_wvalid) r_wstate <= WRRESP;
                WRRESP: if (s_axi_bready) r_wstate <= WRIDLE;
                default: r_wstate <= WRIDLE;
            endcase
        end
    end

    // Read channel FSM; read data captured on the address handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate <= RDIDLE;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                RDIDLE: if (s_axi_arvalid) begin
                    r_rdata  <= (s_axi_araddr[DEC_W-1:0] == A_CTRL) ? C_DATA_WIDTH'(w_ctrl_rd) : '0;
                    r_rstate <= RDDATA;
                end
                RDDATA: if (s_axi_rready) r_rstate <= RDIDLE;
                default: r_rstate <= RDIDLE;
            endcase
        end
    end

    // Baud divisor with byte strobes and sticky overflow (set beats clear)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_baud <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_ctrl && s_axi_wstrb[0]) r_baud[7:0]  <= s_axi_wdata[7:0];
            if (w_wr_ctrl && s_axi_wstrb[1]) r_baud[15:8] <= s_axi_wdata[15:8];
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    // Transmit FIFO storage, pointers and occupancy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= s_axi_wdata[7:0];
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

endmodule
